id_stage: RTL and testbench

- Decode stage directly downstream of instruction fetch; consumes if_pc/if_insn/if_en.
- Reads the general register file and forwards from EX and MEM.
- Resolves branches/jumps, feeding br_taken/br_addr back to fetch, and flags load-use hazards to the pipeline controller.
- Registers decoded control and operands into the ID/EX pipeline register.

---
 rtl/id_stage_if.sv | 44 ++++
 rtl/id_stage.sv | 208 ++++++++++++++++++++
 tb/tb_id_stage.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_stage_if.sv
// rtl/id_stage_if.sv - decode stage fetch, regfile, forwarding, redirect and ID/EX signal bundle
interface id_stage_if;
  logic [29:0] if_pc;
  logic [31:0] if_insn;
  logic        if_en;
  logic [4:0]  gpr_rd_addr_0;
  logic [4:0]  gpr_rd_addr_1;
  logic [31:0] gpr_rd_data_0;
  logic [31:0] gpr_rd_data_1;
  logic [31:0] ex_fwd_data;
  logic [4:0]  mem_dst_addr;
  logic        mem_gpr_we_;
  logic        mem_en;
  logic [31:0] mem_fwd_data;
  logic        br_taken;
  logic [29:0] br_addr;
  logic        ld_hazard;
  logic [29:0] id_pc;
  logic        id_en;
  logic [3:0]  id_alu_op;
  logic [31:0] id_alu_in_0;
  logic [31:0] id_alu_in_1;
  logic [1:0]  id_mem_op;
  logic [31:0] id_mem_wr_data;
  logic [4:0]  id_dst_addr;
  logic        id_gpr_we_;
  logic        id_exp_undef;

  modport slave (
    input  if_pc, if_insn, if_en, gpr_rd_data_0, gpr_rd_data_1, ex_fwd_data,
           mem_dst_addr, mem_gpr_we_, mem_en, mem_fwd_data,
    output gpr_rd_addr_0, gpr_rd_addr_1, br_taken, br_addr, ld_hazard,
           id_pc, id_en, id_alu_op, id_alu_in_0, id_alu_in_1, id_mem_op,
           id_mem_wr_data, id_dst_addr, id_gpr_we_, id_exp_undef
  );

  modport master (
    output if_pc, if_insn, if_en, gpr_rd_data_0, gpr_rd_data_1, ex_fwd_data,
           mem_dst_addr, mem_gpr_we_, mem_en, mem_fwd_data,
    input  gpr_rd_addr_0, gpr_rd_addr_1, br_taken, br_addr, ld_hazard,
           id_pc, id_en, id_alu_op, id_alu_in_0, id_alu_in_1, id_mem_op,
           id_mem_wr_data, id_dst_addr, id_gpr_we_, id_exp_undef
  );
endinterface

// File: rtl/id_stage.sv
// rtl/id_stage.sv - decode stage: operand read and forwarding, branch resolution, ID/EX register
module id_stage #(
  parameter logic [3:0] NOP_ALU_OP = 4'h0
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      stall,
  input  logic      flush,
  id_stage_if.slave bus
);
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ORI  = 6'h09;
  localparam logic [5:0] OP_LDW  = 6'h10;
  localparam logic [5:0] OP_STW  = 6'h11;
  localparam logic [5:0] OP_BEQ  = 6'h20;
  localparam logic [5:0] OP_BNE  = 6'h21;
  localparam logic [5:0] OP_JR   = 6'h22;
  localparam logic [5:0] OP_JAL  = 6'h23;
  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_OR  = 4'h3;
  localparam logic [1:0] MEM_NONE = 2'd0;
  localparam logic [1:0] MEM_LDW  = 2'd1;
  localparam logic [1:0] MEM_STW  = 2'd2;
  localparam logic [4:0] LINK_REG = 5'd31;

  logic [5:0]  op;
  logic [4:0]  ra;
  logic [4:0]  rb;
  logic [4:0]  rc;
  logic [15:0] imm;
  logic [31:0] imm_se;
  logic [31:0] imm_ze;
  logic [29:0] pc_inc;

  assign op     = bus.if_insn[31:26];
  assign ra     = bus.if_insn[25:21];
  assign rb     = bus.if_insn[20:16];
  assign rc     = bus.if_insn[15:11];
  assign imm    = bus.if_insn[15:0];
  assign imm_se = {{16{imm[15]}}, imm};
  assign imm_ze = {16'h0000, imm};
  assign pc_inc = bus.if_pc + 30'd1;

  assign bus.gpr_rd_addr_0 = ra;
  assign bus.gpr_rd_addr_1 = rb;

  logic [29:0] pc_q;
  logic        en_q;
  logic [3:0]  alu_op_q;
  logic [31:0] alu_in_0_q;
  logic [31:0] alu_in_1_q;
  logic [1:0]  mem_op_q;
  logic [31:0] mem_wr_data_q;
  logic [4:0]  dst_addr_q;
  logic        gpr_we_n_q;
  logic        exp_undef_q;

  // EX holds the instruction currently in our own output register, so it wins over MEM.
  logic        ex_hit_0;
  logic        ex_hit_1;
  logic        mem_hit_0;
  logic        mem_hit_1;
  logic [31:0] opnd_0;
  logic [31:0] opnd_1;

  assign ex_hit_0  = en_q && !gpr_we_n_q && (dst_addr_q == ra) && (ra != 5'd0);
  assign ex_hit_1  = en_q && !gpr_we_n_q && (dst_addr_q == rb) && (rb != 5'd0);
  assign mem_hit_0 = bus.mem_en && !bus.mem_gpr_we_ && (bus.mem_dst_addr == ra) && (ra != 5'd0);
  assign mem_hit_1 = bus.mem_en && !bus.mem_gpr_we_ && (bus.mem_dst_addr == rb) && (rb != 5'd0);

  assign opnd_0 = ex_hit_0  ? bus.ex_fwd_data  :
                  mem_hit_0 ? bus.mem_fwd_data : bus.gpr_rd_data_0;
  assign opnd_1 = ex_hit_1  ? bus.ex_fwd_data  :
                  mem_hit_1 ? bus.mem_fwd_data : bus.gpr_rd_data_1;

  logic [3:0]  dec_alu_op;
  logic [31:0] dec_in_0;
  logic [31:0] dec_in_1;
  logic [1:0]  dec_mem_op;
  logic [4:0]  dec_dst;
  logic        dec_we_n;
  logic        dec_undef;
  logic        use_ra;
  logic        use_rb;
  logic        br_cond;
  logic        is_jr;

  always_comb begin
    dec_alu_op = ALU_ADD;
    dec_in_0   = opnd_0;
    dec_in_1   = opnd_1;
    dec_mem_op = MEM_NONE;
    dec_dst    = rb;
    dec_we_n   = 1'b1;
    dec_undef  = 1'b0;
    use_ra     = 1'b1;
    use_rb     = 1'b0;
    br_cond    = 1'b0;
    is_jr      = 1'b0;
    case (op)
      6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05: begin
        dec_alu_op = op[3:0];
        dec_dst    = rc;
        dec_we_n   = 1'b0;
        use_rb     = 1'b1;
      end
      OP_ADDI: begin
        dec_in_1 = imm_se;
        dec_we_n = 1'b0;
      end
      OP_ORI: begin
        dec_alu_op = ALU_OR;
        dec_in_1   = imm_ze;
        dec_we_n   = 1'b0;
      end
      OP_LDW: begin
        dec_in_1   = imm_se;
        dec_mem_op = MEM_LDW;
        dec_we_n   = 1'b0;
      end
      OP_STW: begin
        dec_in_1   = imm_se;
        dec_mem_op = MEM_STW;
        use_rb     = 1'b1;
      end
      OP_BEQ: begin
        use_rb  = 1'b1;
        br_cond = (opnd_0 == opnd_1);
      end
      OP_BNE: begin
        use_rb  = 1'b1;
        br_cond = (opnd_0 != opnd_1);
      end
      OP_JR: begin
        br_cond = 1'b1;
        is_jr   = 1'b1;
      end
      OP_JAL: begin
        use_ra   = 1'b0;
        br_cond  = 1'b1;
        dec_in_0 = {pc_inc, 2'b00};
        dec_in_1 = 32'd0;
        dec_dst  = LINK_REG;
        dec_we_n = 1'b0;
      end
      default: dec_undef = 1'b1;
    endcase
  end

  logic ld_hazard_w;

  assign ld_hazard_w = bus.if_en && en_q && (mem_op_q == MEM_LDW) && (dst_addr_q != 5'd0) &&
                       ((use_ra && (dst_addr_q == ra)) || (use_rb && (dst_addr_q == rb)));

  assign bus.ld_hazard = ld_hazard_w;
  assign bus.br_addr   = is_jr ? opnd_0[31:2] : (pc_inc + imm_se[29:0]);
  assign bus.br_taken  = bus.if_en && !ld_hazard_w && !stall && br_cond;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= 30'd0;
      en_q          <= 1'b0;
      alu_op_q      <= NOP_ALU_OP;
      alu_in_0_q    <= 32'd0;
      alu_in_1_q    <= 32'd0;
      mem_op_q      <= MEM_NONE;
      mem_wr_data_q <= 32'd0;
      dst_addr_q    <= 5'd0;
      gpr_we_n_q    <= 1'b1;
      exp_undef_q   <= 1'b0;
    end else if (!stall) begin
      if (flush || ld_hazard_w) begin
        pc_q          <= bus.if_pc;
        en_q          <= 1'b0;
        alu_op_q      <= NOP_ALU_OP;
        alu_in_0_q    <= 32'd0;
        alu_in_1_q    <= 32'd0;
        mem_op_q      <= MEM_NONE;
        mem_wr_data_q <= 32'd0;
        dst_addr_q    <= 5'd0;
        gpr_we_n_q    <= 1'b1;
        exp_undef_q   <= 1'b0;
      end else begin
        pc_q          <= bus.if_pc;
        en_q          <= bus.if_en;
        alu_op_q      <= dec_alu_op;
        alu_in_0_q    <= dec_in_0;
        alu_in_1_q    <= dec_in_1;
        mem_op_q      <= bus.if_en ? dec_mem_op : MEM_NONE;
        mem_wr_data_q <= opnd_1;
        dst_addr_q    <= dec_dst;
        gpr_we_n_q    <= bus.if_en ? dec_we_n : 1'b1;
        exp_undef_q   <= bus.if_en && dec_undef;
      end
    end
  end

  assign bus.id_pc          = pc_q;
  assign bus.id_en          = en_q;
  assign bus.id_alu_op      = alu_op_q;
  assign bus.id_alu_in_0    = alu_in_0_q;
  assign bus.id_alu_in_1    = alu_in_1_q;
  assign bus.id_mem_op      = mem_op_q;
  assign bus.id_mem_wr_data = mem_wr_data_q;
  assign bus.id_dst_addr    = dst_addr_q;
  assign bus.id_gpr_we_     = gpr_we_n_q;
  assign bus.id_exp_undef   = exp_undef_q;
endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - directed bench for id_stage with a behavioural decode model
module tb_id_stage;
  logic clk = 1'b0;
  logic reset;
  logic stall;
  logic flush;

  id_stage_if bus ();

  id_stage #(.NOP_ALU_OP(4'h0)) dut (
    .clk   (clk),
    .reset (reset),
    .stall (stall),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] rf [32];
  assign bus.gpr_rd_data_0 = rf[bus.gpr_rd_addr_0];
  assign bus.gpr_rd_data_1 = rf[bus.gpr_rd_addr_1];

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [29:0] pc;
    logic        en;
    logic [3:0]  alu;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  mop;
    logic [31:0] wd;
    logic [4:0]  dst;
    logic        gpr_we_;
    logic        undef;
    bit          c_alu;
    bit          c_dst;
    bit          c_wd;
  } st_t;

  st_t m;

  function automatic st_t bubble(input logic [29:0] pc);
    st_t s;
    s.pc = pc; s.en = 1'b0; s.alu = 4'h0; s.a = 32'd0; s.b = 32'd0;
    s.mop = 2'd0; s.wd = 32'd0; s.dst = 5'd0; s.gpr_we_ = 1'b1; s.undef = 1'b0;
    s.c_alu = 1'b1; s.c_dst = 1'b1; s.c_wd = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] opnd(input logic [4:0] src);
    if (src != 5'd0 && m.en && !m.gpr_we_ && m.dst == src) return bus.ex_fwd_data;
    if (src != 5'd0 && bus.mem_en && !bus.mem_gpr_we_ && bus.mem_dst_addr == src) return bus.mem_fwd_data;
    if (src == 5'd0) return 32'd0;
    return rf[src];
  endfunction

  // Expected ID/EX contents and same-cycle outputs for the instruction currently presented.
  function automatic void model(output st_t n, output logic haz, output logic take,
                                output logic [29:0] tgt, output logic is_br);
    logic [5:0]  op;
    logic [4:0]  ra, rb, rc;
    logic [31:0] a, b;
    int          imm_i;
    logic        u_ra, u_rb;
    op = bus.if_insn[31:26];
    ra = bus.if_insn[25:21];
    rb = bus.if_insn[20:16];
    rc = bus.if_insn[15:11];
    imm_i = $signed(bus.if_insn[15:0]);
    a = opnd(ra);
    b = opnd(rb);
    tgt = 30'(longint'(bus.if_pc) + 1 + longint'(imm_i));
    n = bubble(bus.if_pc);
    n.en = bus.if_en;
    n.c_alu = 1'b0; n.c_dst = 1'b0; n.c_wd = 1'b0;
    u_ra = (op != 6'h23);
    u_rb = (op <= 6'h05) || (op == 6'h11) || (op == 6'h20) || (op == 6'h21);
    is_br = op inside {6'h20, 6'h21, 6'h22, 6'h23};
    take = 1'b0;
    case (op)
      6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05: begin
        n.alu = op[3:0]; n.a = a; n.b = b; n.dst = rc; n.gpr_we_ = 1'b0;
        n.c_alu = 1'b1; n.c_dst = 1'b1;
      end
      6'h08: begin
        n.alu = 4'd0; n.a = a; n.b = 32'(imm_i); n.dst = rb; n.gpr_we_ = 1'b0;
        n.c_alu = 1'b1; n.c_dst = 1'b1;
      end
      6'h09: begin
        n.alu = 4'd3; n.a = a; n.b = 32'(bus.if_insn[15:0]); n.dst = rb; n.gpr_we_ = 1'b0;
        n.c_alu = 1'b1; n.c_dst = 1'b1;
      end
      6'h10: begin
        n.alu = 4'd0; n.a = a; n.b = 32'(imm_i); n.mop = 2'd1; n.dst = rb; n.gpr_we_ = 1'b0;
        n.c_alu = 1'b1; n.c_dst = 1'b1;
      end
      6'h11: begin
        n.alu = 4'd0; n.a = a; n.b = 32'(imm_i); n.mop = 2'd2; n.wd = b;
        n.c_alu = 1'b1; n.c_wd = 1'b1;
      end
      6'h20: take = (a == b);
      6'h21: take = (a != b);
      6'h22: begin
        take = 1'b1;
        tgt = 30'(a / 4);
      end
      6'h23: begin
        take = 1'b1;
        n.alu = 4'd0; n.a = 32'((longint'(bus.if_pc) + 1) * 4); n.b = 32'd0;
        n.dst = 5'd31; n.gpr_we_ = 1'b0; n.c_alu = 1'b1; n.c_dst = 1'b1;
      end
      default: n.undef = 1'b1;
    endcase
    if (!bus.if_en) begin
      n.gpr_we_ = 1'b1; n.mop = 2'd0; n.undef = 1'b0;
    end
    haz = bus.if_en && m.en && (m.mop == 2'd1) && (m.dst != 5'd0) &&
          ((u_ra && m.dst == ra) || (u_rb && m.dst == rb));
    take = take && bus.if_en && !haz && !stall;
  endfunction

  initial begin
    st_t         n, nxt;
    logic        haz, take, is_br;
    logic [29:0] tgt;
    @(posedge clk);
    m = bubble(30'd0);
    forever begin
      @(negedge clk);
      chk("m_id_pc", bus.id_pc, m.pc);
      chk("m_id_en", bus.id_en, m.en);
      chk("m_id_gpr_we_", bus.id_gpr_we_, m.gpr_we_);
      chk("m_id_mem_op", bus.id_mem_op, m.mop);
      chk("m_id_exp_undef", bus.id_exp_undef, m.undef);
      if (m.c_alu) begin
        chk("m_id_alu_op", bus.id_alu_op, m.alu);
        chk("m_id_alu_in_0", bus.id_alu_in_0, m.a);
        chk("m_id_alu_in_1", bus.id_alu_in_1, m.b);
      end
      if (m.c_dst) chk("m_id_dst_addr", bus.id_dst_addr, m.dst);
      if (m.c_wd) chk("m_id_mem_wr_data", bus.id_mem_wr_data, m.wd);
      model(n, haz, take, tgt, is_br);
      if (!reset) begin
        chk("m_gpr_rd_addr_0", bus.gpr_rd_addr_0, bus.if_insn[25:21]);
        chk("m_gpr_rd_addr_1", bus.gpr_rd_addr_1, bus.if_insn[20:16]);
        chk("m_ld_hazard", bus.ld_hazard, haz);
        chk("m_br_taken", bus.br_taken, take);
        if (is_br && bus.if_en) chk("m_br_addr", bus.br_addr, tgt);
      end
      if (reset) nxt = bubble(30'd0);
      else if (stall) nxt = m;
      else if (flush || haz) nxt = bubble(bus.if_pc);
      else nxt = n;
      @(posedge clk);
      m = nxt;
    end
  end

  function automatic logic [31:0] rtype(input logic [5:0] op, input logic [4:0] ra,
                                        input logic [4:0] rb, input logic [4:0] rc);
    return {op, ra, rb, rc, 11'd0};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] ra,
                                        input logic [4:0] rb, input logic [15:0] imm);
    return {op, ra, rb, imm};
  endfunction

  task automatic drive(input logic [29:0] pc, input logic [31:0] insn, input logic en);
    bus.if_pc = pc;
    bus.if_insn = insn;
    bus.if_en = en;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h1000 + 32'(i);
    rf[0] = 32'd0; rf[1] = 32'd5; rf[2] = 32'd7; rf[10] = 32'h400;
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(30'd0, 32'd0, 1'b0);
    bus.ex_fwd_data = 32'd0; bus.mem_dst_addr = 5'd0; bus.mem_gpr_we_ = 1'b1;
    bus.mem_en = 1'b0; bus.mem_fwd_data = 32'd0;
    tick(); tick();
    chk("rst_id_en", bus.id_en, 0);
    chk("rst_id_gpr_we_", bus.id_gpr_we_, 1);
    chk("rst_id_alu_op", bus.id_alu_op, 0);
    chk("rst_id_pc", bus.id_pc, 0);
    chk("rst_br_taken", bus.br_taken, 0);
    reset = 1'b0;

    drive(30'h10, rtype(6'h00, 5'd1, 5'd2, 5'd3), 1'b1); tick();
    chk("add_alu_op", bus.id_alu_op, 0);
    chk("add_in0", bus.id_alu_in_0, 5);
    chk("add_in1", bus.id_alu_in_1, 7);
    chk("add_dst", bus.id_dst_addr, 3);
    chk("add_we_", bus.id_gpr_we_, 0);
    chk("add_en", bus.id_en, 1);

    drive(30'h11, itype(6'h08, 5'd0, 5'd4, 16'h0001), 1'b1); tick();
    bus.ex_fwd_data = 32'd1;
    drive(30'h12, rtype(6'h00, 5'd4, 5'd4, 5'd5), 1'b1); tick();
    chk("fwd_ex_in0", bus.id_alu_in_0, 1);
    chk("fwd_ex_in1", bus.id_alu_in_1, 1);

    drive(30'h13, itype(6'h08, 5'd0, 5'd4, 16'h0001), 1'b1); tick();
    bus.ex_fwd_data = 32'd9; bus.mem_en = 1'b1; bus.mem_dst_addr = 5'd4;
    bus.mem_gpr_we_ = 1'b0; bus.mem_fwd_data = 32'd2;
    drive(30'h14, rtype(6'h00, 5'd4, 5'd4, 5'd5), 1'b1); tick();
    chk("fwd_ex_over_mem", bus.id_alu_in_0, 9);
    bus.ex_fwd_data = 32'hdead;
    drive(30'h15, rtype(6'h00, 5'd4, 5'd1, 5'd6), 1'b1); tick();
    chk("fwd_mem_only_in0", bus.id_alu_in_0, 2);
    chk("fwd_mem_only_in1", bus.id_alu_in_1, 5);

    drive(30'h16, itype(6'h08, 5'd0, 5'd0, 16'h0001), 1'b1); tick();
    bus.mem_dst_addr = 5'd0; bus.ex_fwd_data = 32'd55;
    drive(30'h17, rtype(6'h00, 5'd0, 5'd0, 5'd8), 1'b1); tick();
    chk("r0_no_fwd_in0", bus.id_alu_in_0, 0);
    chk("r0_no_fwd_in1", bus.id_alu_in_1, 0);
    bus.mem_en = 1'b0; bus.mem_gpr_we_ = 1'b1;

    drive(30'h20, itype(6'h10, 5'd1, 5'd6, 16'h0004), 1'b1); tick();
    chk("ldw_mem_op", bus.id_mem_op, 1);
    drive(30'h21, rtype(6'h00, 5'd6, 5'd1, 5'd7), 1'b1); #1;
    chk("ld_hazard_set", bus.ld_hazard, 1);
    tick();
    chk("bubble_en", bus.id_en, 0);
    chk("bubble_pc", bus.id_pc, 30'h21);
    bus.mem_en = 1'b1; bus.mem_dst_addr = 5'd6; bus.mem_gpr_we_ = 1'b0; bus.mem_fwd_data = 32'd77;
    #1;
    chk("ld_hazard_clear", bus.ld_hazard, 0);
    tick();
    chk("ld_fwd_in0", bus.id_alu_in_0, 77);
    chk("ld_fwd_en", bus.id_en, 1);
    bus.mem_en = 1'b0; bus.mem_gpr_we_ = 1'b1;

    drive(30'h100, itype(6'h20, 5'd1, 5'd1, 16'hFFFE), 1'b1); #1;
    chk("beq_taken", bus.br_taken, 1);
    chk("beq_addr", bus.br_addr, 30'h0FF);
    tick();
    drive(30'h100, itype(6'h20, 5'd1, 5'd2, 16'hFFFE), 1'b1); #1;
    chk("beq_not_taken", bus.br_taken, 0);
    tick();
    drive(30'h101, itype(6'h21, 5'd1, 5'd2, 16'h0003), 1'b1); #1;
    chk("bne_taken", bus.br_taken, 1);
    chk("bne_addr", bus.br_addr, 30'h105);
    tick();
    drive(30'h102, itype(6'h22, 5'd10, 5'd0, 16'h0000), 1'b1); #1;
    chk("jr_taken", bus.br_taken, 1);
    chk("jr_addr", bus.br_addr, 30'h100);
    tick();
    drive(30'h200, itype(6'h23, 5'd0, 5'd0, 16'h0005), 1'b1); #1;
    chk("jal_addr", bus.br_addr, 30'h206);
    tick();
    chk("jal_in0", bus.id_alu_in_0, 32'h804);
    chk("jal_dst", bus.id_dst_addr, 31);

    drive(30'h300, {6'h3F, 26'd0}, 1'b1); tick();
    chk("undef_flag", bus.id_exp_undef, 1);
    chk("undef_we_", bus.id_gpr_we_, 1);
    drive(30'h301, itype(6'h09, 5'd1, 5'd11, 16'h8001), 1'b1); tick();
    chk("ori_in1", bus.id_alu_in_1, 32'h0000_8001);
    chk("ori_alu_op", bus.id_alu_op, 3);
    drive(30'h302, itype(6'h11, 5'd1, 5'd2, 16'hFFFC), 1'b1); tick();
    chk("stw_mem_op", bus.id_mem_op, 2);
    chk("stw_wr_data", bus.id_mem_wr_data, 7);
    chk("stw_in1", bus.id_alu_in_1, 32'hFFFF_FFFC);

    stall = 1'b1; flush = 1'b1;
    drive(30'h400, itype(6'h22, 5'd10, 5'd0, 16'h0000), 1'b1); #1;
    chk("stall_no_branch", bus.br_taken, 0);
    tick();
    chk("hold_pc", bus.id_pc, 30'h302);
    chk("hold_mem_op", bus.id_mem_op, 2);
    stall = 1'b0;
    drive(30'h401, rtype(6'h00, 5'd1, 5'd2, 5'd12), 1'b1); tick();
    chk("flush_en", bus.id_en, 0);
    chk("flush_pc", bus.id_pc, 30'h401);
    flush = 1'b0;

    drive(30'h402, itype(6'h10, 5'd1, 5'd6, 16'h0000), 1'b0); tick();
    chk("noen_en", bus.id_en, 0);
    chk("noen_mem_op", bus.id_mem_op, 0);
    chk("noen_we_", bus.id_gpr_we_, 1);

    drive(30'h403, rtype(6'h04, 5'd1, 5'd2, 5'd13), 1'b1); tick();
    reset = 1'b1;
    drive(30'h404, itype(6'h22, 5'd10, 5'd0, 16'h0000), 1'b1); tick();
    chk("midrst_en", bus.id_en, 0);
    chk("midrst_pc", bus.id_pc, 0);
    reset = 1'b0;
    drive(30'h405, rtype(6'h05, 5'd2, 5'd1, 5'd14), 1'b1); tick();
    chk("slt_alu_op", bus.id_alu_op, 5);
    drive(30'h406, 32'd0, 1'b0); tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
